// File: rtl/fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// fft_frame_sequencer
//
// Feeds a 32-point FFT core from a one-sample-per-cycle complex stream and
// tags the core's result beats with frame framing information.
//
// Samples arriving on in_* are collected into a one-frame buffer (LANES*BEATS
// complex points). When the frame closes, either by its last slot filling or
// by an early in_last, the buffer is replayed to the core as BEATS
// back-to-back beats of LANES packed samples. Lane 0 sits in the most
// significant SAMPLE_W bits of each beat. Slots never written in a frame
// that closed early read as zero.
//
// A FFT_LATENCY-deep shift line runs alongside the core and carries
// {valid, beat index}. It marks the cycles in which the core's output holds a
// result beat, along with the first and last beat of each result frame.
//
// Ports
//   clk1          in   single clock, rising edge
//   rst           in   asynchronous active-low reset
//   in_valid      in   source sample valid
//   in_ready      out  sample accepted when in_valid & in_ready
//   in_real       in   sample real part (signed Q3.4)
//   in_imag       in   sample imag part (signed Q3.4)
//   in_last       in   sample closes the frame early, rest zero-padded
//   fft_real_in   out  packed real beat to the core
//   fft_imag_in   out  packed imag beat to the core
//   fft_beat_vld  out  fft_*_in carries a frame beat this cycle
//   out_valid     out  core output holds a result beat this cycle
//   out_sof       out  first result beat of a frame
//   out_eof       out  last result beat of a frame
//   out_beat_idx  out  result beat index 0..BEATS-1
//   pad_seen      out  sticky: some frame was closed early and zero-padded
//   frame_cnt     out  frames fully issued to the core, wraps at 2^16
// ---------------------------------------------------------------------------
module fft_frame_sequencer #(
    parameter int SAMPLE_W    = 8,
    parameter int LANES       = 4,
    parameter int BEATS       = 8,
    parameter int FFT_LATENCY = 10
) (
    input  logic                        clk1,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SAMPLE_W-1:0]  in_real,
    input  logic signed [SAMPLE_W-1:0]  in_imag,
    input  logic                        in_last,
    output logic [LANES*SAMPLE_W-1:0]   fft_real_in,
    output logic [LANES*SAMPLE_W-1:0]   fft_imag_in,
    output logic                        fft_beat_vld,
    output logic                        out_valid,
    output logic                        out_sof,
    output logic                        out_eof,
    output logic [2:0]                  out_beat_idx,
    output logic                        pad_seen,
    output logic [15:0]                 frame_cnt
);

    localparam int POINTS = LANES * BEATS;
    localparam int PTR_W  = $clog2(POINTS);
    localparam int IDX_W  = 3;
    localparam int VEC_W  = LANES * SAMPLE_W;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(POINTS - 1);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                       state;
    logic [PTR_W-1:0]             ptr;
    logic [IDX_W-1:0]             beat;
    logic signed [SAMPLE_W-1:0]   sample_re [POINTS];
    logic signed [SAMPLE_W-1:0]   sample_im [POINTS];

    logic                         xfer;
    logic                         frame_close;
    logic [IDX_W-1:0]             next_beat;
    logic [VEC_W-1:0]             next_re;
    logic [VEC_W-1:0]             next_im;

    logic                         line_vld [FFT_LATENCY];
    logic [IDX_W-1:0]             line_idx [FFT_LATENCY];

    // Buffer slot holding lane k of beat b.
    function automatic logic [PTR_W-1:0] slot_of(input logic [IDX_W-1:0] b, input int k);
        return PTR_W'(int'(b) * LANES + k);
    endfunction

    assign xfer        = in_valid & in_ready;
    assign frame_close = xfer & (in_last | (ptr == LAST_PTR));

    // Beat to present on the core input after the coming edge: beat 0 when
    // the frame is closing out of FILL, otherwise the beat after the current.
    assign next_beat = (state == FILL) ? '0 : beat + 1'b1;

    // Assemble the next beat from the buffer. The sample being written on
    // the closing edge is not in the buffer yet, so it is bypassed straight
    // into its lane when it belongs to the beat being assembled.
    always_comb begin
        next_re = '0;
        next_im = '0;
        for (int k = 0; k < LANES; k++) begin
            if (xfer && (ptr == slot_of(next_beat, k))) begin
                next_re[VEC_W-1-k*SAMPLE_W -: SAMPLE_W] = in_real;
                next_im[VEC_W-1-k*SAMPLE_W -: SAMPLE_W] = in_imag;
            end else begin
                next_re[VEC_W-1-k*SAMPLE_W -: SAMPLE_W] = sample_re[slot_of(next_beat, k)];
                next_im[VEC_W-1-k*SAMPLE_W -: SAMPLE_W] = sample_im[slot_of(next_beat, k)];
            end
        end
    end

    // Frame FSM: FILL collects samples, DRAIN replays BEATS beats.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state        <= FILL;
            in_ready     <= 1'b1;
            ptr          <= '0;
            beat         <= '0;
            fft_real_in  <= '0;
            fft_imag_in  <= '0;
            fft_beat_vld <= 1'b0;
            pad_seen     <= 1'b0;
            frame_cnt    <= '0;
            for (int i = 0; i < POINTS; i++) begin
                sample_re[i] <= '0;
                sample_im[i] <= '0;
            end
        end else if (state == FILL) begin
            if (xfer) begin
                sample_re[ptr] <= in_real;
                sample_im[ptr] <= in_imag;
                ptr            <= ptr + 1'b1;
            end
            // The first beat is registered on the closing edge so the core
            // sees beat 0 in the very first DRAIN cycle.
            if (frame_close) begin
                state        <= DRAIN;
                in_ready     <= 1'b0;
                beat         <= '0;
                fft_real_in  <= next_re;
                fft_imag_in  <= next_im;
                fft_beat_vld <= 1'b1;
                // Closing on the final slot is a full frame, not padding.
                if (in_last && (ptr != LAST_PTR)) begin
                    pad_seen <= 1'b1;
                end
            end
        end else begin
            if (beat == LAST_BEAT) begin
                // The buffer is zeroed here so an early-closed next frame
                // finds zeros in every slot it does not write.
                state        <= FILL;
                in_ready     <= 1'b1;
                ptr          <= '0;
                fft_real_in  <= '0;
                fft_imag_in  <= '0;
                fft_beat_vld <= 1'b0;
                frame_cnt    <= frame_cnt + 1'b1;
                for (int i = 0; i < POINTS; i++) begin
                    sample_re[i] <= '0;
                    sample_im[i] <= '0;
                end
            end else begin
                beat        <= beat + 1'b1;
                fft_real_in <= next_re;
                fft_imag_in <= next_im;
            end
        end
    end

    // Tag line mirroring the core latency; idle slots carry index 0 so the
    // index output reads zero whenever no result beat is present.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FFT_LATENCY; i++) begin
                line_vld[i] <= 1'b0;
                line_idx[i] <= '0;
            end
        end else begin
            line_vld[0] <= fft_beat_vld;
            line_idx[0] <= fft_beat_vld ? beat : '0;
            for (int i = 1; i < FFT_LATENCY; i++) begin
                line_vld[i] <= line_vld[i-1];
                line_idx[i] <= line_idx[i-1];
            end
        end
    end

    assign out_valid    = line_vld[FFT_LATENCY-1];
    assign out_beat_idx = line_idx[FFT_LATENCY-1];
    assign out_sof      = out_valid & (out_beat_idx == '0);
    assign out_eof      = out_valid & (out_beat_idx == LAST_BEAT);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// ---------------------------------------------------------------------------
// Bench for fft_frame_sequencer: directed frames from a table, a reset taken
// in the middle of a frame, a frame counter wrap, then random traffic. A
// frame-level reference model tracks every cycle.
// ---------------------------------------------------------------------------
module tb_fft_frame_sequencer;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b0;
    logic        d_valid = 1'b0;
    logic [7:0]  d_re = '0;
    logic [7:0]  d_im = '0;
    logic        d_last = 1'b0;

    logic        in_ready;
    logic [31:0] fft_real_in;
    logic [31:0] fft_imag_in;
    logic        fft_beat_vld;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic [2:0]  out_beat_idx;
    logic        pad_seen;
    logic [15:0] frame_cnt;

    fft_frame_sequencer dut (
        .clk1         (clk1),
        .rst          (rst),
        .in_valid     (d_valid),
        .in_ready     (in_ready),
        .in_real      (d_re),
        .in_imag      (d_im),
        .in_last      (d_last),
        .fft_real_in  (fft_real_in),
        .fft_imag_in  (fft_imag_in),
        .fft_beat_vld (fft_beat_vld),
        .out_valid    (out_valid),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_beat_idx (out_beat_idx),
        .pad_seen     (pad_seen),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // ---------------- reference model (frame level) ----------------
    int          cyc = 0;
    bit          m_ready = 1'b1;
    int          m_left = 0;          // beats still to be shown to the core
    int          m_n = 0;             // samples gathered in the open frame
    logic [7:0]  f_re [32];
    logic [7:0]  f_im [32];
    logic [31:0] m_beats_re [8];
    logic [31:0] m_beats_im [8];
    bit          m_pad = 1'b0;
    logic [15:0] m_cnt = '0;
    int          m_hist [int];        // cycle -> index of beat shown that cycle
    int          preload_seq = 0;
    int          preload_done = 0;

    always @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            m_ready = 1'b1;
            m_left  = 0;
            m_n     = 0;
            m_pad   = 1'b0;
            m_cnt   = '0;
            m_hist.delete();
            preload_done = preload_seq;
        end else begin
            cyc++;
            if (preload_seq != preload_done) begin
                m_cnt = 16'hFFFF;
                preload_done = preload_seq;
            end
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_cnt   = m_cnt + 16'd1;
                    m_ready = 1'b1;
                end
            end else if (m_ready && d_valid) begin
                f_re[m_n] = d_re;
                f_im[m_n] = d_im;
                m_n++;
                if (m_n == 32 || d_last) begin
                    if (d_last && m_n < 32) m_pad = 1'b1;
                    for (int b = 0; b < 8; b++) begin
                        m_beats_re[b] = '0;
                        m_beats_im[b] = '0;
                        for (int k = 0; k < 4; k++) begin
                            if (b * 4 + k < m_n) begin
                                m_beats_re[b][31-8*k -: 8] = f_re[b*4+k];
                                m_beats_im[b][31-8*k -: 8] = f_im[b*4+k];
                            end
                        end
                    end
                    m_n     = 0;
                    m_ready = 1'b0;
                    m_left  = 8;
                end
            end
            if (m_left > 0) m_hist[cyc] = 8 - m_left;
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic tick();
        logic [31:0] er;
        logic [31:0] ei;
        logic        ov;
        logic [2:0]  eidx;
        logic [88:0] req;
        logic [88:0] act;
        @(negedge clk1);
        if (chk_en) begin
            er = '0;
            ei = '0;
            if (m_left > 0) begin
                er = m_beats_re[8-m_left];
                ei = m_beats_im[8-m_left];
            end
            ov   = m_hist.exists(cyc - 10);
            eidx = ov ? 3'(m_hist[cyc-10]) : 3'd0;
            req  = {m_ready, (m_left > 0), er, ei, ov, ov && (eidx == 3'd0),
                    ov && (eidx == 3'd7), eidx, m_pad, m_cnt};
            act  = {in_ready, fft_beat_vld, fft_real_in, fft_imag_in, out_valid,
                    out_sof, out_eof, out_beat_idx, pad_seen, frame_cnt};
            n_checks++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL model_cycle_%0d: got %h, required %h", cyc, act, req);
            end
        end
    endtask

    task automatic send_frame(input int nsamp, input int off, input bit last, input bit tog);
        for (int n = 0; n < nsamp; n++) begin
            if (tog) begin
                d_valid = 1'b0;
                d_last  = 1'b0;
                tick();
            end
            d_valid = 1'b1;
            d_re    = 8'(n + off);
            d_im    = 8'(-(n + off));
            d_last  = last && (n == nsamp - 1);
            tick();
        end
        d_valid = 1'b0;
        d_last  = 1'b0;
    endtask

    // ---------------- directed frame table ----------------
    typedef struct {
        int               nsamp;
        int               off;
        bit               last;
        bit               tog;
        logic [0:7][31:0] re;
        logic [0:7][31:0] im;
        bit               pad;
        logic [15:0]      cnt;
    } frame_t;

    frame_t tab [5];

    initial begin
        int  k;
        bit  seen;

        tab[0] = '{nsamp: 32, off: 0, last: 0, tog: 0,
                   re: {32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                        32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F},
                   im: {32'h00FFFEFD, 32'hFCFBFAF9, 32'hF8F7F6F5, 32'hF4F3F2F1,
                        32'hF0EFEEED, 32'hECEBEAE9, 32'hE8E7E6E5, 32'hE4E3E2E1},
                   pad: 0, cnt: 16'd1};
        tab[1] = tab[0];
        tab[1].tog = 1;
        tab[1].cnt = 16'd2;
        tab[2] = '{nsamp: 32, off: 'h40, last: 1, tog: 0,
                   re: {32'h40414243, 32'h44454647, 32'h48494A4B, 32'h4C4D4E4F,
                        32'h50515253, 32'h54555657, 32'h58595A5B, 32'h5C5D5E5F},
                   im: {32'hC0BFBEBD, 32'hBCBBBAB9, 32'hB8B7B6B5, 32'hB4B3B2B1,
                        32'hB0AFAEAD, 32'hACABAAA9, 32'hA8A7A6A5, 32'hA4A3A2A1},
                   pad: 0, cnt: 16'd3};
        tab[3] = '{nsamp: 6, off: 1, last: 1, tog: 0,
                   re: {32'h01020304, 32'h05060000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                   im: {32'hFFFEFDFC, 32'hFBFA0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                   pad: 1, cnt: 16'd4};
        tab[4] = '{nsamp: 1, off: 'h7F, last: 1, tog: 1,
                   re: {32'h7F000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                   im: {32'h81000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                   pad: 1, cnt: 16'd5};

        // Reset release and idle.
        repeat (3) tick();
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_fft_real_in", fft_real_in, 0);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (fft_beat_vld) seen = 1'b1;
        end
        check("idle_no_beat", seen, 0);

        // Reset in the middle of a frame's beats.
        send_frame(32, 0, 1'b0, 1'b0);
        check("abort_drain_started", fft_beat_vld, 1);
        repeat (3) tick();
        #1 rst = 1'b0;
        #1 check("abort_beat_vld_drops", fft_beat_vld, 0);
        tick();
        tick();
        #1 rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", seen, 0);
        check("abort_frame_cnt", frame_cnt, 0);

        // Directed frames.
        for (int f = 0; f < 5; f++) begin
            send_frame(tab[f].nsamp, tab[f].off, tab[f].last, tab[f].tog);
            check($sformatf("f%0d_drain_start", f), fft_beat_vld, 1);
            for (int b = 0; b < 8; b++) begin
                check($sformatf("f%0d_beat%0d_vld", f, b), fft_beat_vld, 1);
                check($sformatf("f%0d_beat%0d_ready", f, b), in_ready, 0);
                check($sformatf("f%0d_beat%0d_real", f, b), fft_real_in, tab[f].re[b]);
                check($sformatf("f%0d_beat%0d_imag", f, b), fft_imag_in, tab[f].im[b]);
                tick();
            end
            check($sformatf("f%0d_fill_ready", f), in_ready, 1);
            check($sformatf("f%0d_fill_vld", f), fft_beat_vld, 0);
            k = 8;
            while (!out_valid && k < 20) begin
                tick();
                k++;
            end
            check($sformatf("f%0d_out_latency", f), k, 10);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("f%0d_out%0d_valid", f, i), out_valid, 1);
                check($sformatf("f%0d_out%0d_idx", f, i), out_beat_idx, i);
                check($sformatf("f%0d_out%0d_sof", f, i), out_sof, (i == 0));
                check($sformatf("f%0d_out%0d_eof", f, i), out_eof, (i == 7));
                tick();
            end
            check($sformatf("f%0d_out_end", f), out_valid, 0);
            check($sformatf("f%0d_pad_seen", f), pad_seen, tab[f].pad);
            check($sformatf("f%0d_frame_cnt", f), frame_cnt, tab[f].cnt);
        end

        // Frame counter wrap.
        #1 force dut.frame_cnt = 16'hFFFF;
        preload_seq++;
        #1 release dut.frame_cnt;
        tick();
        check("wrap_preload", frame_cnt, 16'hFFFF);
        send_frame(32, 3, 1'b0, 1'b0);
        repeat (12) tick();
        check("wrap_frame_cnt", frame_cnt, 16'h0000);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            d_valid = ($urandom_range(0, 3) != 0);
            d_re    = 8'($urandom);
            d_im    = 8'($urandom);
            d_last  = ($urandom_range(0, 39) == 0);
            tick();
        end
        d_valid = 1'b0;
        d_last  = 1'b0;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
